// File: rtl/if_stage_fetch_if.sv
// Signal bundle between the fetch stage, instruction memory, hazard/branch
// logic and the decode stage.
interface if_stage_fetch_if;
    logic        Stall;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_Valid;
    logic        Halted;
    logic [31:0] Fetch_Count;

    modport master (
        input  Stall, Branch_Taken, Branch_Target, Instruction,
        output Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
               Halted, Fetch_Count
    );

    modport slave (
        output Stall, Branch_Taken, Branch_Target, Instruction,
        input  Inst_Address, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
               Halted, Fetch_Count
    );
endinterface

// File: rtl/if_stage_fetch.sv
// RV64 instruction-fetch stage: PC register, IF/ID pipeline register,
// stall/redirect handling, end-of-program halt detection and fetch counter.
module if_stage_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter logic [31:0] HALT_INST = 32'h0000_0063,
    parameter bit          HALT_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    if_stage_fetch_if.master  bus
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [63:0] pc_p0, pc_nxt;
    logic [63:0] ifid_pc_p1, ifid_pc_nxt;
    logic [31:0] ifid_ins_p1, ifid_ins_nxt;
    logic        vld_p1, vld_nxt;
    logic [31:0] count, count_nxt;
    logic        halt_word;

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    assign halt_word = HALT_EN && (bus.Instruction == HALT_INST);

    // Next-state: redirect beats stall; a halted stage ignores stall and only emits bubbles.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_p0;
        ifid_pc_nxt  = ifid_pc_p1;
        ifid_ins_nxt = ifid_ins_p1;
        vld_nxt      = vld_p1;
        count_nxt    = count;
        if (bus.Branch_Taken) begin
            pc_nxt       = bus.Branch_Target & ~64'h3;
            ifid_pc_nxt  = 64'h0;
            ifid_ins_nxt = NOP_INST;
            vld_nxt      = 1'b0;
            state_nxt    = RUN;
        end else if (state == HALT) begin
            ifid_pc_nxt  = 64'h0;
            ifid_ins_nxt = NOP_INST;
            vld_nxt      = 1'b0;
        end else if (!bus.Stall) begin
            ifid_pc_nxt  = pc_p0;
            ifid_ins_nxt = bus.Instruction;
            vld_nxt      = 1'b1;
            count_nxt    = sat_inc(count);
            if (halt_word) begin
                state_nxt = HALT;
            end else begin
                pc_nxt = pc_p0 + 64'd4;
            end
        end
    end

    // Fetch / IF-ID boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_p0       <= RESET_PC;
            ifid_pc_p1  <= 64'h0;
            ifid_ins_p1 <= NOP_INST;
            vld_p1      <= 1'b0;
            count       <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc_p0       <= pc_nxt;
            ifid_pc_p1  <= ifid_pc_nxt;
            ifid_ins_p1 <= ifid_ins_nxt;
            vld_p1      <= vld_nxt;
            count       <= count_nxt;
        end
    end

    assign bus.Inst_Address      = pc_p0;
    assign bus.IF_ID_PC          = ifid_pc_p1;
    assign bus.IF_ID_Instruction = ifid_ins_p1;
    assign bus.IF_ID_Valid       = vld_p1;
    assign bus.Halted            = (state == HALT);
    assign bus.Fetch_Count       = count;

endmodule
